// File: rtl/one_wire_master.sv
// one_wire_master: bit-level 1-Wire bus master with open-drain output.
// Executes one command at a time: bus reset with presence detect, write-bit
// slot, read-bit slot, or no-op. All timing is counted in clk cycles.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   i_cmd_valid   command request (taken only while o_cmd_ready is high)
//   i_cmd         00 bus reset, 01 write bit, 10 read bit, 11 no-op
//   i_wr_bit      bit to write, latched at acceptance
//   o_cmd_ready   idle, can accept a command
//   i_bus         raw line level (asynchronous, synchronized internally)
//   o_bus_oe      1 = drive line low, 0 = release
//   o_done        one-cycle completion pulse
//   o_presence    slave answered the last bus reset
//   o_rd_bit      value captured by the last read slot
//   o_busy        command in progress
module one_wire_master #(
  parameter int RESET_LOW       = 480,
  parameter int PRESENCE_SAMPLE = 70,
  parameter int SLOT_LEN        = 70,
  parameter int WRITE0_LOW      = 60,
  parameter int WRITE1_LOW      = 6,
  parameter int READ_LOW        = 6,
  parameter int READ_SAMPLE     = 15,
  parameter int RECOVERY        = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd,
  input  logic       i_wr_bit,
  output logic       o_cmd_ready,
  input  logic       i_bus,
  output logic       o_bus_oe,
  output logic       o_done,
  output logic       o_presence,
  output logic       o_rd_bit,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_HIGH, RECOVER
  } state_t;

  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_NOP   = 2'b11;

  state_t      state, state_nxt;
  logic [15:0] timer;
  logic [1:0]  cmd_q;
  logic        wr_bit_q;
  logic        bus_s1, bus_s2;
  logic        accept;
  logic [15:0] low_len;
  logic [15:0] slot_idx;
  logic        bus_oe_d, done_d, presence_d, rd_bit_d;

  assign o_cmd_ready = (state == IDLE);
  assign o_busy      = ~o_cmd_ready;
  assign accept      = i_cmd_valid & o_cmd_ready;

  // Low time of the current slot, from the latched command.
  always_comb begin
    low_len = 16'(READ_LOW);
    if (cmd_q == CMD_WRITE)
      low_len = wr_bit_q ? 16'(WRITE1_LOW) : 16'(WRITE0_LOW);
  end

  // The timer restarts in SLOT_HIGH, so the slot-relative index is rebuilt
  // by adding back the low time already spent.
  always_comb begin
    slot_idx = timer;
    if (state == SLOT_HIGH)
      slot_idx = low_len + timer;
  end

  // State register, timer, synchronizer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      cmd_q      <= CMD_NOP;
      wr_bit_q   <= 1'b0;
      bus_s1     <= 1'b1;
      bus_s2     <= 1'b1;
      o_bus_oe   <= 1'b0;
      o_done     <= 1'b0;
      o_presence <= 1'b0;
      o_rd_bit   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE)
        timer <= '0;
      else
        timer <= timer + 16'd1;
      if (accept) begin
        cmd_q    <= i_cmd;
        wr_bit_q <= i_wr_bit;
      end
      bus_s1     <= i_bus;
      bus_s2     <= bus_s1;
      o_bus_oe   <= bus_oe_d;
      o_done     <= done_d;
      o_presence <= presence_d;
      o_rd_bit   <= rd_bit_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (i_cmd)
            CMD_RESET: state_nxt = RST_LOW;
            CMD_WRITE,
            CMD_READ:  state_nxt = SLOT_LOW;
            default:   state_nxt = IDLE;
          endcase
        end
      end
      RST_LOW:   if (timer == 16'(RESET_LOW - 1)) state_nxt = RST_WAIT;
      RST_WAIT:  if (timer == 16'(RESET_LOW - 1)) state_nxt = IDLE;
      SLOT_LOW:  if (timer == low_len - 16'd1)    state_nxt = SLOT_HIGH;
      SLOT_HIGH: if (timer == 16'(SLOT_LEN) - low_len - 16'd1) state_nxt = RECOVER;
      RECOVER:   if (timer == 16'(RECOVERY - 1))  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output logic: computes the next value of each registered output, so
  // o_bus_oe follows the state being entered with no combinational path.
  always_comb begin
    bus_oe_d   = (state_nxt == RST_LOW) || (state_nxt == SLOT_LOW);
    done_d     = ((state != IDLE) && (state_nxt == IDLE)) ||
                 (accept && (i_cmd == CMD_NOP));
    presence_d = o_presence;
    rd_bit_d   = o_rd_bit;
    if (state == RST_WAIT && timer == 16'(PRESENCE_SAMPLE))
      presence_d = ~bus_s2;
    if (cmd_q == CMD_READ && (state == SLOT_LOW || state == SLOT_HIGH) &&
        slot_idx == 16'(READ_SAMPLE))
      rd_bit_d = bus_s2;
  end

endmodule

// File: doc/one_wire_master.md
ONE_WIRE_MASTER -- requirements
Module: one_wire_master

Interface
REQ-001 Parameter RESET_LOW, default 480: reset-pulse low time, clk cycles (1 clk = 1 us).
REQ-002 Parameter PRESENCE_SAMPLE, default 70: cycles after reset-pulse release to presence sample.
REQ-003 Parameter SLOT_LEN, default 70: write/read slot length, cycles, counted from slot start.
REQ-004 Parameter WRITE0_LOW, default 60: low time, write-0 slot.
REQ-005 Parameter WRITE1_LOW, default 6: low time, write-1 slot.
REQ-006 Parameter READ_LOW, default 6: low time, read slot.
REQ-007 Parameter READ_SAMPLE, default 15: slot cycle index at which read data is sampled.
REQ-008 Parameter RECOVERY, default 10: released-bus gap after each slot.
REQ-009 clk  input  1  clock.
REQ-010 reset  input  1  reset, asynchronous, active-high.
REQ-011 i_cmd_valid  input  1  command request.
REQ-012 i_cmd  input  2  00 bus reset, 01 write bit, 10 read bit, 11 no-op.
REQ-013 i_wr_bit  input  1  bit to write; sampled at acceptance.
REQ-014 o_cmd_ready  output  1  block can accept a command.
REQ-015 i_bus  input  1  raw one-wire line level.
REQ-016 o_bus_oe  output  1  1 = pull line low; 0 = release (open-drain).
REQ-017 o_done  output  1  one-cycle command-complete pulse.
REQ-018 o_presence  output  1  1 = slave answered last bus reset.
REQ-019 o_rd_bit  output  1  value from last read slot.
REQ-020 o_busy  output  1  command in progress (inverse of o_cmd_ready).

Function
REQ-021 States: IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_HIGH, RECOVER; one timer of >=10 bits, cleared on every state entry.
REQ-022 o_cmd_ready=1 only in IDLE; acceptance = i_cmd_valid & o_cmd_ready at rising clk; i_cmd, i_wr_bit latched then.
REQ-023 i_bus passes through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-024 Reset cmd: RST_LOW, o_bus_oe=1 exactly RESET_LOW cycles starting the cycle after acceptance; then RST_WAIT, o_bus_oe=0 for RESET_LOW cycles.
REQ-025 In RST_WAIT at timer==PRESENCE_SAMPLE: o_presence <= ~synced bus; held until next reset-cmd sample.
REQ-026 Write cmd: SLOT_LOW with o_bus_oe=1 for WRITE0_LOW (bit 0) or WRITE1_LOW (bit 1) cycles; SLOT_HIGH released until SLOT_LEN total slot cycles; RECOVER released RECOVERY cycles.
REQ-027 Read cmd: same slot structure with READ_LOW low time; at slot cycle index READ_SAMPLE (cycle 0 = first low cycle): o_rd_bit <= synced bus; held until next read sample.
REQ-028 Latency acceptance-to-o_done: reset 2*RESET_LOW+1 cycles; write/read SLOT_LEN+RECOVERY+1 cycles; no-op 1 cycle, no bus activity.
REQ-029 o_done pulses in the first IDLE cycle after completion; a new command may be accepted in that same cycle (back-to-back, no extra gap).
REQ-030 o_bus_oe is a registered output, never glitches; high only in RST_LOW and SLOT_LOW.
REQ-031 i_cmd_valid while busy is ignored (not queued); i_cmd/i_wr_bit changes mid-command have no effect.
REQ-032 Bus held low externally during RST_WAIT/SLOT_HIGH: no error, timing unchanged, sampled value reflects line.

Reset
REQ-033 On reset assertion, immediately and asynchronously: state IDLE, o_bus_oe=0, o_done=0, o_presence=0, o_rd_bit=0, o_busy=0, timer=0, synchronizer flops=1.
REQ-034 Reset mid-command aborts without o_done; o_cmd_ready=1 first cycle after reset release.

Verification
REQ-035 Reset cmd, slave model pulls bus low cycles 30..150 after release -> o_bus_oe high 480 cycles, o_presence=1, o_done 961 cycles after acceptance.
REQ-036 Reset cmd, no slave (bus high) -> o_presence=0, o_done at 961, o_bus_oe low afterward.
REQ-037 Write 1 then write 0 back-to-back -> o_bus_oe low-pulses of 6 and 60 cycles, slot starts 81 cycles apart; slave sampler at 50 cycles reads 1 then 0.
REQ-038 Read slots, slave holds bus low cycles 0..40 vs not -> o_rd_bit=0 vs 1, o_done 81 cycles after acceptance.
REQ-039 Assert reset at cycle 20 of RST_LOW -> o_bus_oe=0 same cycle, no o_done, next reset cmd accepted and timed correctly.
REQ-040 Cmd 11 and i_cmd_valid during busy -> no-op o_done after 1 cycle, no o_bus_oe; busy-time request ignored.
